wall_layout_loader: RTL

Level-layout sequencer for the maze wall renderer. On a level change it walks the wall-descriptor ROM for the selected level and writes each wall's position and size into the renderer's wall register bank through a valid/ready write port. Loads start only during vertical blanking so a frame is never drawn with a half-updated maze. It sits between the game-state FSM, which requests levels, and the wall generator, which consumes the descriptors.

---
 rtl/wall_layout_loader_if.sv | 47 ++++
 rtl/wall_layout_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wall_layout_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wall_layout_loader_if: descriptor ROM read port and wall-bank write port  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface wall_layout_loader_if #(
  parameter int ADDR_W = 6,
  parameter int IDX_W  = 5
);
  logic [ADDR_W-1:0] rom_addr;
  logic [37:0]       rom_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_idx;
  logic [9:0]        wr_x;
  logic [8:0]        wr_y;
  logic [9:0]        wr_w;
  logic [8:0]        wr_h;
  logic              wr_en;

  modport master (
    output rom_addr,
    input  rom_data,
    output wr_valid,
    input  wr_ready,
    output wr_idx,
    output wr_x,
    output wr_y,
    output wr_w,
    output wr_h,
    output wr_en
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  wr_valid,
    output wr_ready,
    input  wr_idx,
    input  wr_x,
    input  wr_y,
    input  wr_w,
    input  wr_h,
    input  wr_en
  );
endinterface
`default_nettype wire

// File: rtl/wall_layout_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wall_layout_loader: copies a level's wall descriptors from ROM into the   |
// | renderer wall bank, starting only in vblank. Option: WALL_LOAD_VBLANK_GATE_EN |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module wall_layout_loader #(
  parameter  int NUM_WALLS  = 26,
  parameter  int NUM_LEVELS = 2,
  localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             level_req,
  input  wire logic [LVL_W-1:0] level_sel,
  input  wire logic             vblank,
  wall_layout_loader_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [LVL_W-1:0]      cur_level
);

  localparam int IDX_W  = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam int ADDR_W = $clog2(NUM_WALLS * NUM_LEVELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VB = 3'd1,
    S_FETCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q,     state_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [LVL_W-1:0]  load_lvl_q,  load_lvl_d;
  logic              pend_q,      pend_d;
  logic [LVL_W-1:0]  pend_lvl_q,  pend_lvl_d;
  logic [LVL_W-1:0]  cur_level_q, cur_level_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              wr_valid_q,  wr_valid_d;
  logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
  logic [9:0]        wr_x_q,      wr_x_d;
  logic [8:0]        wr_y_q,      wr_y_d;
  logic [9:0]        wr_w_q,      wr_w_d;
  logic [8:0]        wr_h_q,      wr_h_d;
  logic              wr_en_q,     wr_en_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_lvl_d  = load_lvl_q;
    pend_d      = pend_q;
    pend_lvl_d  = pend_lvl_q;
    cur_level_d = cur_level_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_valid_d  = wr_valid_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_w_d      = wr_w_q;
    wr_h_d      = wr_h_q;
    wr_en_d     = wr_en_q;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          load_lvl_d = pend_lvl_q;
          pend_d     = 1'b0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_WAIT_VB;
        end
      end
      S_WAIT_VB: begin
        if (vblank) state_d = S_FETCH;
      end
      S_FETCH: begin
        // rom_addr has been stable for this whole cycle, so rom_data is valid now.
        wr_x_d     = bus.rom_data[37:28];
        wr_y_d     = bus.rom_data[27:19];
        wr_w_d     = bus.rom_data[18:9];
        wr_h_d     = bus.rom_data[8:0];
        wr_en_d    = (bus.rom_data[18:9] != '0) && (bus.rom_data[8:0] != '0);
        wr_valid_d = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (bus.wr_ready) begin
          wr_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
`ifdef WALL_LOAD_VBLANK_GATE_EN
            state_d = vblank ? S_FETCH : S_WAIT_VB;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
      S_DONE: begin
        busy_d      = 1'b0;
        cur_level_d = load_lvl_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new request always wins over the consume in IDLE, so it is never lost.
    if (level_req) begin
      pend_d     = 1'b1;
      pend_lvl_d = level_sel;
    end

    rom_addr_d = ADDR_W'(int'(load_lvl_d) * NUM_WALLS + int'(idx_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      load_lvl_q  <= '0;
      pend_q      <= 1'b1;
      pend_lvl_q  <= '0;
      cur_level_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      rom_addr_q  <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_w_q      <= '0;
      wr_h_q      <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      load_lvl_q  <= load_lvl_d;
      pend_q      <= pend_d;
      pend_lvl_q  <= pend_lvl_d;
      cur_level_q <= cur_level_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_valid_q  <= wr_valid_d;
      rom_addr_q  <= rom_addr_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_w_q      <= wr_w_d;
      wr_h_q      <= wr_h_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_idx   = idx_q;
  assign bus.wr_x     = wr_x_q;
  assign bus.wr_y     = wr_y_q;
  assign bus.wr_w     = wr_w_q;
  assign bus.wr_h     = wr_h_q;
  assign bus.wr_en    = wr_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_level    = cur_level_q;

endmodule
`default_nettype wire
